// File: rtl/ex_alu_stage.sv
// EX-stage ALU / address-calculation datapath feeding the EX/MEM register.
// Define EX_MUL_EN to add the iterative shift-add multiplier (function 8).
module ex_alu_stage #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instruction,
  input  logic              AddrCalSignal,
  input  logic [3:0]        Function,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] StoreData,
  output logic [3:0]        DestReg,
  output logic [3:0]        OpCodeOut,
  output logic              Zero,
  output logic              Busy
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] res_q, res_d, store_q, store_d;
  logic [3:0]        dest_q, dest_d, op_q, op_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] alu_res, imm_ext;
  logic              idle, accept, start_mul;
  logic              unused_instr;

  assign unused_instr = ^Instruction[23:16];
  assign imm_ext = {{(DATA_W-16){Instruction[15]}}, Instruction[15:0]};

  always_comb begin
    alu_res = '0;
    if (AddrCalSignal) begin
      alu_res = OperandA + imm_ext;
    end else begin
      case (Function)
        4'd0:    alu_res = OperandA + OperandB;
        4'd1:    alu_res = OperandA - OperandB;
        4'd2:    alu_res = OperandA & OperandB;
        4'd3:    alu_res = OperandA | OperandB;
        4'd4:    alu_res = OperandA ^ OperandB;
        4'd5:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(OperandA) < $signed(OperandB))};
        4'd6:    alu_res = OperandA << OperandB[4:0];
        4'd7:    alu_res = OperandA >> OperandB[4:0];
        default: alu_res = '0;
      endcase
    end
  end

`ifdef EX_MUL_EN
  typedef enum logic {S_IDLE, S_MULT} state_t;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [DATA_W-1:0] pstore_q, pstore_d, acc_step;
  logic [3:0]        pdest_q, pdest_d, pop_q, pop_d;
  logic              mul_done;

  assign idle      = (state_q == S_IDLE);
  assign Busy      = (state_q == S_MULT);
  assign start_mul = accept && !AddrCalSignal && (Function == 4'd8);
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done  = (state_q == S_MULT) && (cnt_q == CNT_W'(MUL_CYCLES-1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    pstore_d = pstore_q;
    pdest_d  = pdest_q;
    pop_d    = pop_q;
    case (state_q)
      S_IDLE: begin
        if (start_mul) begin
          state_d  = S_MULT;
          cnt_d    = '0;
          mcand_d  = OperandA;
          mplier_d = OperandB;
          acc_d    = '0;
          pstore_d = OperandB;
          pdest_d  = Instruction[27:24];
          pop_d    = Instruction[31:28];
        end
      end
      S_MULT: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      pstore_q <= '0;
      pdest_q  <= '0;
      pop_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      pstore_q <= pstore_d;
      pdest_q  <= pdest_d;
      pop_q    <= pop_d;
    end
  end
`else
  assign idle      = 1'b1;
  assign Busy      = 1'b0;
  assign start_mul = 1'b0;
`endif

  assign InReady = idle && (!valid_q || OutReady) && !Flush;
  assign accept  = InValid && InReady;

  // Flush only kills valid; data registers keep whatever they last held.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    store_d = store_q;
    dest_d  = dest_q;
    op_d    = op_q;
    zero_d  = zero_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else begin
      if (valid_q && OutReady) valid_d = 1'b0;
      if (accept && !start_mul) begin
        res_d   = alu_res;
        store_d = OperandB;
        dest_d  = Instruction[27:24];
        op_d    = Instruction[31:28];
        zero_d  = (alu_res == '0);
        valid_d = 1'b1;
      end
`ifdef EX_MUL_EN
      if (mul_done) begin
        res_d   = acc_step;
        store_d = pstore_q;
        dest_d  = pdest_q;
        op_d    = pop_q;
        zero_d  = (acc_step == '0);
        valid_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      store_q <= '0;
      dest_q  <= '0;
      op_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      store_q <= store_d;
      dest_q  <= dest_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
    end
  end

  assign OutValid  = valid_q;
  assign ALUResult = res_q;
  assign StoreData = store_q;
  assign DestReg   = dest_q;
  assign OpCodeOut = op_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed scenarios plus randomized traffic against
// a transaction-level reference model.
module tb_ex_alu_stage;
  localparam int MUL_CYCLES = 32;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic InValid = 1'b0, InReady, AddrCalSignal = 1'b0, Flush = 1'b0;
  logic OutValid, OutReady = 1'b1, Zero, Busy;
  logic [31:0] Instruction = '0, OperandA = '0, OperandB = '0;
  logic [3:0]  Function = '0, DestReg, OpCodeOut;
  logic [31:0] ALUResult, StoreData;

  int n_cmp = 0, n_fail = 0;

  // reference model state
  bit          m_valid, m_zero;
  logic [31:0] m_res, m_store, p_res, p_store;
  logic [3:0]  m_dest, m_op, p_dest, p_op;
  int          m_rem;

  ex_alu_stage #(.DATA_W(32), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
    .Instruction(Instruction), .AddrCalSignal(AddrCalSignal), .Function(Function),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .ALUResult(ALUResult),
    .StoreData(StoreData), .DestReg(DestReg), .OpCodeOut(OpCodeOut),
    .Zero(Zero), .Busy(Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic addr, input logic [3:0] fn,
                                             input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b);
    int signed sa, sb;
    if (addr) return a + {{16{ins[15]}}, ins[15:0]};
    sa = a; sb = b;
    case (fn)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return MUL_EN ? a * b : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit acc;
    logic [31:0] r;
    acc = InValid && !rst && (m_rem == 0) && (!m_valid || OutReady) && !Flush;
    r = ref_result(AddrCalSignal, Function, Instruction, OperandA, OperandB);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_zero = 0; m_res = 0; m_store = 0; m_dest = 0; m_op = 0; m_rem = 0;
    end else if (Flush) begin
      m_valid = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_res = p_res; m_store = p_store; m_dest = p_dest; m_op = p_op;
        m_zero = (p_res == 0); m_valid = 1;
      end
    end else begin
      if (m_valid && OutReady) m_valid = 0;
      if (acc) begin
        if (MUL_EN && !AddrCalSignal && Function == 4'd8) begin
          m_rem = MUL_CYCLES; p_res = r; p_store = OperandB;
          p_dest = Instruction[27:24]; p_op = Instruction[31:28];
        end else begin
          m_res = r; m_store = OperandB; m_dest = Instruction[27:24];
          m_op = Instruction[31:28]; m_zero = (r == 0); m_valid = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic addr, input logic [3:0] fn, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b);
    AddrCalSignal = addr; Function = fn; Instruction = ins; OperandA = a; OperandB = b;
  endtask

  task automatic test_reset();
    rst = 1; InValid = 1; set_op(0, 4'd0, 32'h1234_5678, 32'd3, 32'd4);
    tick(); tick();
    rst = 0; InValid = 0; OutReady = 1;
    #1;
    n_cmp++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
    n_cmp++; if (ALUResult !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", ALUResult); end
    n_cmp++; if (StoreData !== 32'd0) begin n_fail++; $display("FAIL reset_store got=%h exp=0", StoreData); end
    n_cmp++; if (DestReg !== 4'd0 || OpCodeOut !== 4'd0) begin n_fail++; $display("FAIL reset_dest_op got=%h/%h exp=0/0", DestReg, OpCodeOut); end
    n_cmp++; if (Zero !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL reset_zero_busy got=%b/%b exp=0/0", Zero, Busy); end
    n_cmp++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready got=%b exp=1", InReady); end
  endtask

  task automatic test_addr_calc();
    InValid = 1; set_op(1, 4'd1, {4'h3, 4'h5, 8'h00, 16'hFFFC}, 32'h0000_1000, 32'hDEAD_BEEF);
    tick();
    InValid = 0;
    n_cmp++; if (ALUResult !== 32'h0000_0FFC) begin n_fail++; $display("FAIL addr_result got=%h exp=00000ffc", ALUResult); end
    n_cmp++; if (OutValid !== 1'b1 || Zero !== 1'b0) begin n_fail++; $display("FAIL addr_valid_zero got=%b/%b exp=1/0", OutValid, Zero); end
    n_cmp++; if (StoreData !== 32'hDEAD_BEEF || DestReg !== 4'h5 || OpCodeOut !== 4'h3)
      begin n_fail++; $display("FAIL addr_capture got=%h/%h/%h exp=deadbeef/5/3", StoreData, DestReg, OpCodeOut); end
    tick();
  endtask

  task automatic test_back_to_back();
    OutReady = 1; InValid = 1; set_op(0, 4'd1, 32'h1100_0000, 32'd5, 32'd5);
    #1;
    n_cmp++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got=%b exp=1", InReady); end
    tick();
    n_cmp++; if (ALUResult !== 32'd0 || Zero !== 1'b1 || OutValid !== 1'b1)
      begin n_fail++; $display("FAIL b2b_sub got=%h z=%b v=%b exp=0 z=1 v=1", ALUResult, Zero, OutValid); end
    set_op(0, 4'd5, 32'h1200_0000, 32'hFFFF_FFFF, 32'd1);
    #1;
    n_cmp++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", InReady); end
    tick();
    n_cmp++; if (ALUResult !== 32'd1 || Zero !== 1'b0 || OutValid !== 1'b1 || DestReg !== 4'h2)
      begin n_fail++; $display("FAIL b2b_slt got=%h z=%b v=%b d=%h exp=1 z=0 v=1 d=2", ALUResult, Zero, OutValid, DestReg); end
    InValid = 0;
    tick();
    n_cmp++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", OutValid); end
  endtask

  task automatic test_stall();
    InValid = 1; OutReady = 1; set_op(0, 4'd0, 32'h1300_0000, 32'd7, 32'd8);
    tick();
    OutReady = 0; set_op(0, 4'd4, 32'h1400_0000, 32'h0000_00F0, 32'h0000_000F);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d got=%b exp=0", i, InReady); end
      n_cmp++; if (ALUResult !== 32'd15 || OutValid !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold c%0d got=%h v=%b exp=f v=1", i, ALUResult, OutValid); end
      tick();
    end
    n_cmp++; if (ALUResult !== 32'd15) begin n_fail++; $display("FAIL stall_end got=%h exp=f", ALUResult); end
    OutReady = 1;
    #1;
    n_cmp++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", InReady); end
    tick();
    n_cmp++; if (ALUResult !== 32'h0000_00FF || OutValid !== 1'b1 || DestReg !== 4'h4)
      begin n_fail++; $display("FAIL stall_next got=%h v=%b d=%h exp=ff v=1 d=4", ALUResult, OutValid, DestReg); end
    InValid = 0;
    tick();
  endtask

  task automatic test_mul();
    int busy_cycles, waited;
    OutReady = 1; InValid = 1; set_op(0, 4'd8, 32'h1700_0000, 32'h0001_0000, 32'h0001_0003);
    tick();
    InValid = 0;
    if (MUL_EN) begin
      busy_cycles = 0; waited = 0;
      while (OutValid !== 1'b1 && waited < 60) begin
        if (Busy === 1'b1) busy_cycles++;
        n_cmp++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL mul_ready w%0d got=%b exp=0", waited, InReady); end
        tick(); waited++;
      end
      n_cmp++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL mul_timeout got=%b exp=1", OutValid); end
      n_cmp++; if (busy_cycles != MUL_CYCLES) begin n_fail++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", busy_cycles, MUL_CYCLES); end
      n_cmp++; if (ALUResult !== 32'h0003_0000 || DestReg !== 4'h7 || StoreData !== 32'h0001_0003)
        begin n_fail++; $display("FAIL mul_result got=%h d=%h s=%h exp=00030000 d=7 s=00010003", ALUResult, DestReg, StoreData); end
    end else begin
      n_cmp++; if (ALUResult !== 32'd0 || OutValid !== 1'b1 || Zero !== 1'b1 || Busy !== 1'b0)
        begin n_fail++; $display("FAIL mul_disabled got=%h v=%b z=%b b=%b exp=0 v=1 z=1 b=0", ALUResult, OutValid, Zero, Busy); end
    end
    tick();
  endtask

  task automatic test_flush();
    int seen;
    OutReady = 0; InValid = 1; set_op(0, 4'd0, 32'h1200_0000, 32'd1, 32'd2);
    tick();
    Flush = 1; set_op(0, 4'd0, 32'h1900_0000, 32'd10, 32'd20);
    #1;
    n_cmp++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", InReady); end
    tick();
    Flush = 0; InValid = 0; OutReady = 1;
    n_cmp++; if (OutValid !== 1'b0 || ALUResult !== 32'd3 || DestReg !== 4'h2)
      begin n_fail++; $display("FAIL flush_reg got v=%b r=%h d=%h exp v=0 r=3 d=2", OutValid, ALUResult, DestReg); end
    if (MUL_EN) begin
      InValid = 1; set_op(0, 4'd8, 32'h1600_0000, 32'd3, 32'd4);
      tick();
      InValid = 0;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL flush_mul_busy got=%b exp=1", Busy); end
      Flush = 1; InValid = 1; set_op(0, 4'd0, 32'h1900_0000, 32'd10, 32'd20);
      tick();
      Flush = 0; InValid = 0;
      n_cmp++; if (Busy !== 1'b0 || OutValid !== 1'b0)
        begin n_fail++; $display("FAIL flush_mul_abort got b=%b v=%b exp b=0 v=0", Busy, OutValid); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (OutValid === 1'b1) seen++;
        tick();
      end
      n_cmp++; if (seen != 0 || ALUResult !== 32'd3)
        begin n_fail++; $display("FAIL flush_mul_leak got valid_cycles=%0d r=%h exp 0 r=3", seen, ALUResult); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      Flush    = ($urandom_range(0, 19) == 0);
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) b = a;
      set_op(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), $urandom, a, b);
      #1;
      if (!rst) begin
        n_cmp++;
        if (InReady !== ((m_rem == 0) && (!m_valid || OutReady) && !Flush))
          begin n_fail++; $display("FAIL rnd_inready c%0d got=%b", c, InReady); end
      end
      tick();
      n_cmp++; if (OutValid !== m_valid) begin n_fail++; $display("FAIL rnd_outvalid c%0d got=%b exp=%b", c, OutValid, m_valid); end
      n_cmp++; if (Busy !== (m_rem > 0)) begin n_fail++; $display("FAIL rnd_busy c%0d got=%b exp=%b", c, Busy, (m_rem > 0)); end
      n_cmp++; if (ALUResult !== m_res || Zero !== m_zero)
        begin n_fail++; $display("FAIL rnd_result c%0d got=%h z=%b exp=%h z=%b", c, ALUResult, Zero, m_res, m_zero); end
      n_cmp++; if (StoreData !== m_store || DestReg !== m_dest || OpCodeOut !== m_op)
        begin n_fail++; $display("FAIL rnd_capture c%0d got=%h/%h/%h exp=%h/%h/%h", c, StoreData, DestReg, OpCodeOut, m_store, m_dest, m_op); end
    end
    rst = 0; Flush = 0; InValid = 0;
  endtask

  initial begin
    m_valid = 0; m_zero = 0; m_res = 0; m_store = 0; m_dest = 0; m_op = 0; m_rem = 0;
    p_res = 0; p_store = 0; p_dest = 0; p_op = 0;
    @(negedge clk);
    test_reset();
    test_addr_calc();
    test_back_to_back();
    test_stall();
    test_mul();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute-stage datapath of the 4-bit-opcode MIPS pipeline, directly downstream of the EX local controller.
- Consumes the AddrCalSignal/Function decode plus the register operands and performs ALU or address calculation.
- Registers the result, destination and flags into the EX/MEM boundary.
- Valid/ready handshake on both sides so the memory stage and an optional multi-cycle multiplier can stall the pipe.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_CYCLES, 32, iterations of the shift-add multiplier (used only with EX_MUL_EN).

Ports:
- clk  input  1  pipeline clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- InValid  input  1  upstream holds a valid instruction.
- InReady  output  1  stage can accept this cycle.
- Instruction  input  32  [31:28] opcode, [27:24] Rd, [15:0] Imm.
- AddrCalSignal  input  1  1 = address calculation (LW/SW).
- Function  input  4  ALU function from the local controller.
- OperandA  input  DATA_W  Rs value.
- OperandB  input  DATA_W  Rt value / store data.
- Flush  input  1  kill in-flight and registered instruction.
- OutValid  output  1  EX/MEM register holds a valid result.
- OutReady  input  1  memory stage consumes this cycle.
- ALUResult  output  DATA_W  result or effective address.
- StoreData  output  DATA_W  OperandB captured at accept.
- DestReg  output  4  Instruction[27:24] captured at accept.
- OpCodeOut  output  4  Instruction[31:28] captured at accept.
- Zero  output  1  ALUResult == 0.
- Busy  output  1  multiplier in progress.

Behaviour:
- Reset: all outputs 0; state IDLE; iteration counter 0. Reset mid-multiply aborts it with no output.
- InReady = (state==IDLE) && (!OutValid || OutReady) && !Flush. Accept = InValid && InReady.
- AddrCalSignal=1: result = OperandA + sign-extended Imm[15:0]; Function ignored.
- AddrCalSignal=0, functions:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed, result 0/1).
  - 6 SLL, 7 SRL (shift amount OperandB[4:0]).
  - 8 MUL (low 32 bits).
  - 9-15: result 0.
- Arithmetic wraps mod 2^DATA_W; no overflow trap.
- Single-cycle functions: result, StoreData, DestReg, OpCodeOut and Zero load on the accept edge; OutValid=1 next cycle (latency 1).
- Registered outputs hold stable while OutValid && !OutReady.
- OutValid clears on OutReady unless a new accept occurs the same cycle, which gives back-to-back throughput of 1/cycle.
- States:
  - IDLE: accept of MUL -> MULT; anything else stays in IDLE.
  - MULT: Busy=1, counter increments per cycle; at count MUL_CYCLES-1 load outputs, OutValid=1 -> IDLE. MUL latency = MUL_CYCLES+1 from accept.
- InReady=0 throughout MULT.
- Flush (highest priority after rst): OutValid->0, MULT->IDLE, counter->0, and any same-cycle InValid is dropped. Data outputs keep their old values.
- Zero is computed from the value being loaded into ALUResult.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: function 8 runs the iterative shift-add multiplier through the MULT state as described above.
- Undefined: no multiplier logic or MULT state; function 8 behaves like 9-15 (result 0, latency 1); Busy tied 0.

Test Plan:
- rst held 2 cycles, then released -> all outputs 0, InReady=1.
- Accept AddrCal=1, OperandA=0x1000, Imm=0xFFFC -> next cycle ALUResult=0x0FFC, OutValid=1, Zero=0.
- Function=1, A=5, B=5, then Function=5 with A=0xFFFFFFFF, B=1 on consecutive cycles, OutReady=1 -> results 0 (Zero=1) then 1.
- OutReady=0 for 3 cycles after ADD 7+8 -> ALUResult stays 15, InReady=0; on OutReady=1 the next input is accepted the same cycle.
- EX_MUL_EN defined: MUL 0x00010000 x 0x00010003 -> Busy=1 for 32 cycles, InReady=0, then ALUResult=0x00030000. Undefined: ALUResult=0 after 1 cycle.
- Flush asserted mid-MUL with InValid=1 -> OutValid stays 0, Busy drops next cycle, dropped input is never output.
